// File: rtl/fb_pkg.sv
// Framebuffer geometry, RGB565 packing and address helpers for pixel_writer.
// PIXEL_WRITER_DITHER_EN adds the 4x4 Bayer dither helpers.
package fb_pkg;

  localparam int FB_W_DEF = 800;
  localparam int FB_H_DEF = 480;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int AW = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_DRAIN
  } pw_state_t;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
  } win_t;

  // {R,G,B} 8:8:8 -> {B[7:3], G[7:2], R[7:3]}
  function automatic logic [15:0] rgb888_to_rgb565(
    input logic [23:0] p
  );
    return {p[7:3], p[15:10], p[23:19]};
  endfunction

  function automatic logic [AW-1:0] pack_addr(
    input logic [YW-1:0] y,
    input logic [XW-1:0] x
  );
    return {1'b0, y, x};
  endfunction

`ifdef PIXEL_WRITER_DITHER_EN
  // Classic 4x4 ordered-dither matrix, row = y[1:0], col = x[1:0]
  function automatic logic [3:0] bayer4(
    input logic [3:0] idx
  );
    logic [3:0] t;
    t = 4'd0;
    unique case (idx)
      4'd0:  t = 4'd0;
      4'd1:  t = 4'd8;
      4'd2:  t = 4'd2;
      4'd3:  t = 4'd10;
      4'd4:  t = 4'd12;
      4'd5:  t = 4'd4;
      4'd6:  t = 4'd14;
      4'd7:  t = 4'd6;
      4'd8:  t = 4'd3;
      4'd9:  t = 4'd11;
      4'd10: t = 4'd1;
      4'd11: t = 4'd9;
      4'd12: t = 4'd15;
      4'd13: t = 4'd7;
      4'd14: t = 4'd13;
      4'd15: t = 4'd5;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] sat_add8(
    input logic [7:0] c,
    input logic [3:0] a
  );
    logic [8:0] s;
    s = {1'b0, c} + {5'd0, a};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Threshold 0..15 becomes 0..7 for the 5-bit fields, 0..3 for green
  function automatic logic [15:0] dither565(
    input logic [23:0] p,
    input logic [1:0]  y2,
    input logic [1:0]  x2
  );
    logic [3:0] t;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    t = bayer4({y2, x2});
    r = sat_add8(p[23:16], {1'b0, t[3:1]});
    g = sat_add8(p[15:8], {2'b0, t[3:2]});
    b = sat_add8(p[7:0], {1'b0, t[3:1]});
    return rgb888_to_rgb565({r, g, b});
  endfunction
`endif

endpackage

// File: rtl/pixel_writer_coord.sv
// Raster position counter over a latched window.
// Load at window start, advance per accepted pixel, flag the last one.
module pixel_writer_coord
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          advance,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          last
);

  // Step along the row, wrap to x0 and drop a row at x1
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (load) begin
      cur_x <= x0;
      cur_y <= y0;
    end else if (advance) begin
      if (cur_x == x1) begin
        cur_x <= x0;
        cur_y <= cur_y + 1'b1;
      end else begin
        cur_x <= cur_x + 1'b1;
      end
    end
  end

  assign last = (cur_x == x1) && (cur_y == y1);

endmodule

// File: rtl/pixel_writer.sv
// Avalon-ST RGB888 sink writing a window into the RGB565 framebuffer.
// PIXEL_WRITER_DITHER_EN selects Bayer dither instead of truncation.
module pixel_writer
  import fb_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] win_x0,
  input  logic [YW-1:0] win_y0,
  input  logic [XW-1:0] win_x1,
  input  logic [YW-1:0] win_y1,
  output logic          busy,
  output logic          done,
  output logic          win_err,
  input  logic [23:0]   st_pixel_data,
  input  logic          st_pixel_valid,
  output logic          st_pixel_ready,
  output logic [AW-1:0] mm_address,
  output logic          mm_write,
  output logic [15:0]   mm_writedata,
  input  logic          mm_waitrequest
);

  localparam logic [XW:0] XLIM = (XW+1)'(FB_W);
  localparam logic [YW:0] YLIM = (YW+1)'(FB_H);

  pw_state_t     state_q;
  pw_state_t     state_d;
  win_t          win_q;
  logic          win_bad;
  logic          wr_free;
  logic          accept;
  logic          load;
  logic          done_d;
  logic          err_set;
  logic          err_clr;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          last;
  logic [15:0]   pix565;

  assign wr_free = !mm_write || !mm_waitrequest;
  assign accept  = st_pixel_valid && st_pixel_ready;
  assign busy    = (state_q != S_IDLE);

  assign win_bad = (win_q.x0 > win_q.x1)
                || (win_q.y0 > win_q.y1)
                || ({1'b0, win_q.x1} >= XLIM)
                || ({1'b0, win_q.y1} >= YLIM);

`ifdef PIXEL_WRITER_DITHER_EN
  assign pix565 = dither565(st_pixel_data,
                            cur_y[1:0],
                            cur_x[1:0]);
`else
  assign pix565 = rgb888_to_rgb565(st_pixel_data);
`endif

  pixel_writer_coord u_coord (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (accept),
    .x0      (win_q.x0),
    .y0      (win_q.y0),
    .x1      (win_q.x1),
    .y1      (win_q.y1),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .last    (last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state, sink ready and status strobes
  always_comb begin
    state_d        = state_q;
    st_pixel_ready = 1'b0;
    load           = 1'b0;
    done_d         = 1'b0;
    err_set        = 1'b0;
    err_clr        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_clr = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (win_bad) begin
          done_d  = 1'b1;
          err_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          load    = 1'b1;
          err_clr = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        st_pixel_ready = wr_free;
        if (st_pixel_valid && wr_free && last)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_free) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Window is captured only when a start is honoured
  always_ff @(posedge clk) begin
    if (reset)
      win_q <= '0;
    else if (state_q == S_IDLE && start)
      win_q <= '{x0: win_x0, y0: win_y0,
                 x1: win_x1, y1: win_y1};
  end

  // Write request register: load on accept, hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      mm_write     <= 1'b0;
      mm_address   <= '0;
      mm_writedata <= '0;
    end else if (accept) begin
      mm_write     <= 1'b1;
      mm_address   <= pack_addr(cur_y, cur_x);
      mm_writedata <= pix565;
    end else if (!mm_waitrequest) begin
      mm_write     <= 1'b0;
    end
  end

  // Completion pulse and sticky window error
  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      win_err <= 1'b0;
    end else begin
      done <= done_d;
      if (err_clr)      win_err <= 1'b0;
      else if (err_set) win_err <= 1'b1;
    end
  end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Avalon-ST sink of RGB888 pixels and Avalon-MM write initiator into the 800x480 RGB565 framebuffer.
- Writes a software-selected rectangular window in raster order: x0..x1 within a row, then y0..y1.
- Uses the same address map and RGB565 bit packing that the scanout-side pixel fetch consumes.
- Sits between the rasteriser/blit pipeline and the framebuffer memory controller.

Parameters:
- FB_W, 800, framebuffer width in pixels; x ranges 0..FB_W-1.
- FB_H, 480, framebuffer height in pixels; y ranges 0..FB_H-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches the window and begins a transfer (honoured only when idle)
- win_x0  in  10  window left column, inclusive
- win_y0  in  9  window top row, inclusive
- win_x1  in  10  window right column, inclusive
- win_y1  in  9  window bottom row, inclusive
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the transfer finishes or is rejected
- win_err  out  1  set together with done when the window was invalid; held until the next start
- st_pixel_data  in  24  {R[7:0], G[7:0], B[7:0]}
- st_pixel_valid  in  1  source has a pixel
- st_pixel_ready  out  1  sink accepts a pixel; ready latency 0
- mm_address  out  20  {1'b0, y[8:0], x[9:0]}
- mm_write  out  1  write request
- mm_writedata  out  16  {B[7:3], G[7:2], R[7:3]}
- mm_waitrequest  in  1  slave stall

Behaviour:
- Reset: state IDLE; mm_write=0, mm_address=0, mm_writedata=0, busy=0, done=0, win_err=0. st_pixel_ready is 0 whenever the state is not RUN.
- States:
  - IDLE --start--> CHECK (window registers latched).
  - CHECK: window invalid if x0>x1, y0>y1, x1>=FB_W or y1>=FB_H.
    - Invalid: done=1, win_err=1, back to IDLE, no MM traffic.
    - Valid: cur_x=x0, cur_y=y0, win_err=0, go to RUN.
  - RUN: st_pixel_ready = !mm_write || !mm_waitrequest (combinational).
    - On valid&&ready: next cycle mm_write=1, mm_address={0,cur_y,cur_x}, mm_writedata=pack(data); cur position advances.
    - Advance rule: if cur_x==x1 then cur_x=x0 and cur_y++, else cur_x++.
    - When the accepted pixel is (x1,y1), go to DRAIN.
  - DRAIN: st_pixel_ready=0. Once no write is outstanding (mm_write==0, or mm_write && !mm_waitrequest this cycle): done=1 next cycle, busy=0, go to IDLE.
- Throughput and latency:
  - One pixel per clock with no waitrequest.
  - Latency from ST accept to mm_write assertion is 1 cycle.
- MM hold: while mm_write && mm_waitrequest, mm_address and mm_writedata are held stable. With no new pixel, mm_write drops the cycle after acceptance.
- Simultaneous: write acceptance and new pixel acceptance in the same cycle produce back-to-back writes with no bubble.
- start while busy or in CHECK is ignored.
- Reset mid-transfer: immediate return to IDLE, any in-flight write abandoned, no done pulse.
- A single-pixel window (x0==x1, y0==y1) goes RUN -> DRAIN after one pixel.

Optional Feature:
- Macro PIXEL_WRITER_DITHER_EN.
- Defined: 4x4 ordered Bayer dither indexed by {cur_y[1:0], cur_x[1:0]}.
  - Threshold 0..15 scaled to 0..7 for R/B and 0..3 for G.
  - Added to each channel before truncation, saturating at 255.
  - Adds no latency.
- Undefined: plain truncation.

Decomposition:
- Package fb_pkg: FB_W/FB_H defaults, coordinate widths, rgb888_to_rgb565 function, address-pack function, Bayer 4x4 table (dither build only).
- Sub-module pixel_writer_coord: window position counter with load, advance and last-pixel flag.

Test Plan:
- Window (0,0)-(3,0), data 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF, no waitrequest -> writes to addr 0x00000..0x00003 of 0x001F, 0x07E0, 0xF800, 0xFFFF on consecutive cycles; done 1 cycle after the last write.
- Window (798,478)-(799,479) -> address sequence 0x77B1E, 0x77B1F, 0x77F1E, 0x77F1F; done pulses once.
- waitrequest held 3 cycles on the 2nd write -> address and data stable, st_pixel_ready=0 for those cycles, no pixel lost or duplicated.
- win_x0=5, win_x1=4 -> done and win_err in the cycle after CHECK, zero mm_write cycles, ready never asserted.
- Reset asserted mid-RUN after 2 pixels -> next cycle mm_write=0, busy=0, done=0; a new start then begins at (x0,y0).
- Dither build, pixel 0x030303 at (1,0) vs (0,0) -> differing LSB of RGB565 fields per the Bayer table; 0xFFFFFF -> 0xFFFF everywhere.
